fetch_unit: RTL and testbench

Instruction fetch stage for the five-stage pipeline: issues in-order word fetches to instruction memory over a request/grant interface and buffers returned words in a small fetch queue. It drives the IF/ID pipeline register that feeds the decode stage. It also accepts the freeze (hazard stall) and taken-branch redirect signals back from decode, with branch redirect flushing the queue and any in-flight fetches.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a small fetch queue feeding the IF/ID register.
// Latency: grant -> queue push (+1) -> IF/ID (+1); branch target reaches IF/ID 3 cycles after br_taken.
// Backpressure: freeze holds IF/ID; requests stop once queue + live in-flight fetches reach FQ_DEPTH.
//
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt        fetch request handshake (request held until granted)
//   imem_rvalid/imem_rdata             in-order response words
//   freeze                             hold IF/ID, no pop
//   br_taken/br_addr                   redirect: flush queue, drop in-flight responses
//   inst_valid/instruction/inst_pc     IF/ID register (NOP = all zero)
// Optional macro IF_PERF_CNT_EN adds perf_bubble_cnt and perf_flush_cnt (32-bit, wrapping).
module fetch_unit #(
  parameter int                  WORD_LEN = 32,
  parameter int                  FQ_DEPTH = 4,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rstn,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  input  logic                freeze,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_addr,
  output logic                inst_valid,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] inst_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_bubble_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = AW + 1;
  // Stale responses from back-to-back redirects can push the in-flight
  // total past FQ_DEPTH, so give the counter extra headroom.
  localparam int IW = AW + 3;

  logic [WORD_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_LEN-1:0] resp_pc_q, resp_pc_d;
  logic [IW-1:0]       inflight_q, inflight_d;
  logic [IW-1:0]       drop_q, drop_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic                valid_q, valid_d;
  logic [WORD_LEN-1:0] instr_q, instr_d;
  logic [WORD_LEN-1:0] pc_q, pc_d;

  logic [WORD_LEN-1:0] q_pc_q   [FQ_DEPTH];
  logic [WORD_LEN-1:0] q_word_q [FQ_DEPTH];

  logic [IW-1:0] live;
  logic          grant;
  logic          push;
  logic          pop;
  logic          bubble;

  // Credit check counts only live (non-dropped) fetches against queue space.
  assign live     = inflight_q - drop_q;
  assign imem_req = !br_taken && ((live + IW'(count_q)) < IW'(FQ_DEPTH));
  assign grant    = imem_req && imem_gnt;
  // A word arriving together with br_taken would be flushed anyway.
  assign push     = imem_rvalid && (drop_q == '0) && !br_taken;
  assign pop      = !br_taken && !freeze && (count_q != '0);
  assign bubble   = !br_taken && !freeze && (count_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + IW'(grant) - IW'(imem_rvalid);
    drop_d     = drop_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;

    if (grant) fetch_pc_d = fetch_pc_q + WORD_LEN'(4);
    if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - IW'(1);
    if (push) begin
      resp_pc_d = resp_pc_q + WORD_LEN'(4);
      wr_ptr_d  = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    if (br_taken) begin
      valid_d    = 1'b0;
      instr_d    = '0;
      pc_d       = '0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = br_addr;
      resp_pc_d  = br_addr;
      // Every fetch still outstanding belongs to the old path.
      drop_d     = inflight_d;
    end else if (freeze) begin
      valid_d = valid_q;
    end else if (count_q != '0) begin
      valid_d = 1'b1;
      instr_d = q_word_q[rd_ptr_q];
      pc_d    = q_pc_q[rd_ptr_q];
    end else begin
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_q[wr_ptr_q]   <= resp_pc_q;
      q_word_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign inst_valid  = valid_q;
  assign instruction = instr_q;
  assign inst_pc     = pc_q;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (bubble)   perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (br_taken) perf_flush_cnt  <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven vectors, directed corner sequences and randomized traffic
// against a queue-based reference model of the fetch stage.
module tb_fetch_unit;
  localparam int WL = 32;
  localparam int D  = 4;
  localparam logic [WL-1:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          rstn;
  logic          imem_req;
  logic [WL-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [WL-1:0] imem_rdata;
  logic          freeze;
  logic          br_taken;
  logic [WL-1:0] br_addr;
  logic          inst_valid;
  logic [WL-1:0] instruction;
  logic [WL-1:0] inst_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   perf_bubble_cnt;
  logic [31:0]   perf_flush_cnt;
`endif

  fetch_unit #(.WORD_LEN(WL), .FQ_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .freeze(freeze), .br_taken(br_taken), .br_addr(br_addr),
    .inst_valid(inst_valid), .instruction(instruction), .inst_pc(inst_pc)
`ifdef IF_PERF_CNT_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_no);
    end
  endtask

  // ---------------- instruction memory model ----------------
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          lat_fix  = 1;
  bit          lat_rand = 0;
  logic [31:0] data_xor = 32'h0;
  int          grant_cnt = 0;

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  ent_t        m_q[$];
  int          m_infl, m_drop, m_bub, m_fl;
  logic [31:0] m_fetch, m_resp, m_ins, m_pc;
  logic        m_v;
  bit          model_chk = 0;

  task automatic model_reset();
    m_q.delete();
    m_infl = 0; m_drop = 0; m_bub = 0; m_fl = 0;
    m_fetch = RPC; m_resp = RPC;
    m_v = 1'b0; m_ins = 32'h0; m_pc = 32'h0;
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rstn = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    freeze = 1'b0; br_taken = 1'b0; br_addr = 32'h0;
    #1;
    if (check) begin
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_pc", inst_pc, 32'h0);
      chk("rst_addr", imem_addr, RPC);
    end
    mq.delete();
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    if (check) chk("rst_req", imem_req, 1'b1);
  endtask

  // One clock cycle: drive inputs at negedge, sample request before the edge,
  // then advance memory and model, and compare IF/ID after the edge.
  task automatic step(input logic g, input logic f, input logic b, input logic [31:0] ba,
                      output logic req_s, output logic [31:0] addr_s);
    logic        rv;
    logic [31:0] rd;
    logic        m_req;
    ent_t        h;
    @(negedge clk);
    imem_gnt = g; freeze = f; br_taken = b; br_addr = ba;
    rv = 1'b0; rd = 32'h0;
    if (mq.size() > 0) begin
      if (mq[0].due <= edge_no + 1) begin
        rv = 1'b1;
        rd = mq[0].addr ^ data_xor;
      end
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? rd : $urandom;
    #1;
    req_s  = imem_req;
    addr_s = imem_addr;
    m_req  = !b && ((m_infl - m_drop + m_q.size()) < D);
    if (model_chk) begin
      chk("imem_req", req_s, m_req);
      chk("imem_addr", addr_s, m_fetch);
    end
    @(posedge clk);
    edge_no++;
    if (rv) void'(mq.pop_front());
    if (req_s && g) begin
      mq.push_back('{addr_s, edge_no + (lat_rand ? int'($urandom_range(1, 4)) : lat_fix)});
      grant_cnt++;
    end
    // reference: IF/ID from the pre-edge queue, then response, grant, redirect
    if (b) begin
      m_v = 1'b0; m_ins = 32'h0; m_pc = 32'h0;
    end else if (!f) begin
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        m_v = 1'b1; m_ins = h.w; m_pc = h.pc;
      end else begin
        m_v = 1'b0; m_ins = 32'h0; m_pc = 32'h0;
        m_bub++;
      end
    end
    if (rv) begin
      m_infl--;
      if (m_drop > 0) m_drop--;
      else begin
        m_q.push_back('{m_resp, rd});
        m_resp += 4;
      end
    end
    if (m_req && g) begin
      m_infl++;
      m_fetch += 4;
    end
    if (b) begin
      m_q.delete();
      m_fetch = ba; m_resp = ba;
      m_drop = m_infl;
      m_fl++;
    end
    #1;
    if (model_chk) begin
      chk("inst_valid", inst_valid, m_v);
      chk("instruction", instruction, m_ins);
      chk("inst_pc", inst_pc, m_pc);
`ifdef IF_PERF_CNT_EN
      chk("perf_bubble", perf_bubble_cnt, m_bub);
      chk("perf_flush", perf_flush_cnt, m_fl);
`endif
    end
  endtask

  typedef struct {
    logic        g, f, b;
    logic [31:0] ba;
    logic        ereq;   // request during the cycle
    logic [31:0] eaddr;  // address during the cycle
    logic        ev;     // IF/ID valid after the edge
    logic [31:0] epc;    // IF/ID pc after the edge (instruction == pc)
  } vec_t;
  vec_t tv[24];

  initial begin
    logic        rq;
    logic [31:0] ad;
    int          first_pc;
    bit          stale;

    rstn = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    freeze = 1'b0; br_taken = 1'b0; br_addr = 32'h0;
    model_reset();

    // 1-cycle memory, data == address
    tv[0]  = '{1, 0, 0, 32'h0,   1, 32'h00,  0, 32'h0};
    tv[1]  = '{1, 0, 0, 32'h0,   1, 32'h04,  0, 32'h0};
    tv[2]  = '{1, 0, 0, 32'h0,   1, 32'h08,  1, 32'h0};
    tv[3]  = '{1, 0, 0, 32'h0,   1, 32'h0C,  1, 32'h4};
    tv[4]  = '{0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h8};
    tv[5]  = '{0, 0, 0, 32'h0,   1, 32'h10,  1, 32'hC};
    tv[6]  = '{0, 0, 0, 32'h0,   1, 32'h10,  0, 32'h0};
    tv[7]  = '{1, 0, 0, 32'h0,   1, 32'h10,  0, 32'h0};
    tv[8]  = '{1, 0, 0, 32'h0,   1, 32'h14,  0, 32'h0};
    tv[9]  = '{1, 0, 0, 32'h0,   1, 32'h18,  1, 32'h10};
    tv[10] = '{1, 1, 0, 32'h0,   1, 32'h1C,  1, 32'h10};
    tv[11] = '{1, 1, 0, 32'h0,   1, 32'h20,  1, 32'h10};
    tv[12] = '{1, 1, 0, 32'h0,   0, 32'h24,  1, 32'h10};
    tv[13] = '{1, 1, 0, 32'h0,   0, 32'h24,  1, 32'h10};
    tv[14] = '{1, 0, 0, 32'h0,   0, 32'h24,  1, 32'h14};
    tv[15] = '{1, 0, 0, 32'h0,   1, 32'h24,  1, 32'h18};
    tv[16] = '{1, 0, 1, 32'h100, 0, 32'h28,  0, 32'h0};
    tv[17] = '{1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    tv[18] = '{1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0};
    tv[19] = '{1, 0, 0, 32'h0,   1, 32'h108, 1, 32'h100};
    tv[20] = '{1, 1, 1, 32'h200, 0, 32'h10C, 0, 32'h0};
    tv[21] = '{1, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0};
    tv[22] = '{1, 0, 0, 32'h0,   1, 32'h204, 0, 32'h0};
    tv[23] = '{1, 0, 0, 32'h0,   1, 32'h208, 1, 32'h200};

    do_reset(1'b1);
    for (int i = 0; i < 24; i++) begin
      step(tv[i].g, tv[i].f, tv[i].b, tv[i].ba, rq, ad);
      chk($sformatf("tbl%0d_req", i), rq, tv[i].ereq);
      chk($sformatf("tbl%0d_addr", i), ad, tv[i].eaddr);
      chk($sformatf("tbl%0d_valid", i), inst_valid, tv[i].ev);
      chk($sformatf("tbl%0d_pc", i), inst_pc, tv[i].epc);
      chk($sformatf("tbl%0d_instr", i), instruction, tv[i].ev ? tv[i].epc : 32'h0);
    end

    model_chk = 1;

    // freeze from reset: exactly D grants, then request drops; drain back-to-back
    do_reset(1'b0);
    grant_cnt = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, rq, ad);
    chk("frz_grants", grant_cnt, D);
    chk("frz_req_low", rq, 1'b0);
    chk("frz_hold_nop", inst_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, rq, ad);
      chk($sformatf("drain%0d_valid", i), inst_valid, 1'b1);
      chk($sformatf("drain%0d_pc", i), inst_pc, 32'(4 * i));
    end

    // redirect with 3 fetches in flight on a 3-cycle memory
    do_reset(1'b0);
    lat_fix = 3;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, rq, ad);
    step(1'b1, 1'b0, 1'b1, 32'h100, rq, ad);
    first_pc = -1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, rq, ad);
      if (inst_valid) begin
        if (inst_pc < 32'h100) stale = 1;
        if (first_pc < 0) first_pc = int'(inst_pc);
      end
    end
    chk("br_first_pc", first_pc, 32'h100);
    chk("br_no_stale", stale, 1'b0);

    // randomized traffic against the reference model, with a mid-run reset
    lat_rand = 1;
    data_xor = 32'h5A5A_0000;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset(1'b1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 15) == 0, 32'($urandom_range(0, 1023)) << 2, rq, ad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
